extend_unit: RTL and testbench

- Registered 16-to-32-bit immediate extender for the datapath's immediate/operand path.
- Selects zero-extension or sign-extension of a 16-bit input under a one-bit control.
- Presents the result on a registered 32-bit output with a valid flag.
- Sits between instruction-field decode and ALU operand muxing.

---
 rtl/extend_unit.sv | 56 +++++
 tb/tb_extend_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/extend_unit.sv
// extend_unit: registered IN_W-to-OUT_W immediate extender.
// Zero- or sign-extends the operand under a one-bit control. The result
// lands in a single register stage with a valid flag one cycle later.
module extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  a,
    input  logic             sext,
    output logic [OUT_W-1:0] b,
    output logic             out_valid
);

    logic [OUT_W-1:0] b_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] b_next;

    // The low bits always pass the operand through unchanged.
    assign b_next[IN_W-1:0] = a;

    generate
        if (OUT_W > IN_W) begin : g_upper
            // All upper bits carry the same fill value. Gating by sext
            // gives zero-extension when sext=0. It also gives zeros when
            // sext=1 and the operand is non-negative.
            logic fill_bit;
            assign fill_bit = sext & a[IN_W-1];

            for (genvar gi = IN_W; gi < OUT_W; gi++) begin : g_fill
                assign b_next[gi] = fill_bit;
            end
        end
    endgenerate

    // Output stage: reset has priority, and idle cycles hold b.
    // The next value is only sampled on in_valid cycles, so an unknown
    // sext during idle never reaches the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else if (in_valid) begin
            b_reg         <= b_next;
            out_valid_reg <= 1'b1;
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign b         = b_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_extend_unit.sv
// tb_extend_unit: directed and randomized checks of extend_unit against an
// arithmetic reference model.
module tb_extend_unit;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IN_W-1:0]  a;
    logic             sext;
    logic [OUT_W-1:0] b;
    logic             out_valid;

    int total = 0;
    int bad   = 0;

    // Reference state: what b should currently hold.
    logic [OUT_W-1:0] exp_b;

    extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .sext      (sext),
        .b         (b),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // The extension expressed as arithmetic. A negative 16-bit value, read
    // as two's complement, is (a - 2^16). Taken modulo 2^32, that equals
    // a + (2^32 - 2^16).
    function automatic logic [OUT_W-1:0] model_ext(input logic [IN_W-1:0] av, input logic sv);
        longint unsigned val;
        val = longint'(av);
        if (sv && av >= 16'd32768)
            val = val + (64'd4294967296 - 64'd65536);
        return val[OUT_W-1:0];
    endfunction

    // Drive one cycle of stimulus, then settle just past the rising edge.
    task automatic step(input logic r, input logic iv, input logic [IN_W-1:0] av, input logic sv);
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        a        = av;
        sext     = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        exp_b = '0;
        total++;
        if (b !== 32'h0000_0000) begin
            bad++;
            $display("FAIL reset_b got=%h exp=%h", b, 32'h0);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [IN_W-1:0]  av [6];
        logic             sv [6];
        logic [OUT_W-1:0] ev [6];
        av[0] = 16'h0000; sv[0] = 1'b1; ev[0] = 32'h0000_0000;
        av[1] = 16'h8000; sv[1] = 1'b0; ev[1] = 32'h0000_8000;
        av[2] = 16'h8000; sv[2] = 1'b1; ev[2] = 32'hFFFF_8000;
        av[3] = 16'hFFFF; sv[3] = 1'b0; ev[3] = 32'h0000_FFFF;
        av[4] = 16'hFFFF; sv[4] = 1'b1; ev[4] = 32'hFFFF_FFFF;
        av[5] = 16'h1234; sv[5] = 1'b1; ev[5] = 32'h0000_1234;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, av[i], sv[i]);
            exp_b = ev[i];
            total++;
            if (b !== ev[i] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL directed[%0d] a=%h sext=%b got b=%h v=%b exp b=%h v=1",
                         i, av[i], sv[i], b, out_valid, ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 16'h7FFF, 1'b1);
        total++;
        if (b !== 32'h0000_7FFF || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got b=%h v=%b exp b=00007fff v=1", b, out_valid);
        end
        step(1'b0, 1'b1, 16'h8001, 1'b1);
        exp_b = 32'hFFFF_8001;
        total++;
        if (b !== 32'hFFFF_8001 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second got b=%h v=%b exp b=ffff8001 v=1", b, out_valid);
        end
    endtask

    task automatic test_idle();
        // An unknown sext and operand while idle must not disturb b.
        step(1'b0, 1'b0, 16'hxxxx, 1'bx);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid got=%b exp=0", out_valid);
        end
        total++;
        if (b !== exp_b) begin
            bad++;
            $display("FAIL idle_hold got=%h exp=%h", b, exp_b);
        end
        step(1'b0, 1'b0, 16'h5555, 1'b1);
        total++;
        if (b !== exp_b || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold2 got b=%h v=%b exp b=%h v=0", b, out_valid, exp_b);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 16'hABCD, 1'b1);
        total++;
        if (b !== 32'hFFFF_ABCD || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_load got b=%h v=%b exp b=ffffabcd v=1", b, out_valid);
        end
        step(1'b1, 1'b1, 16'h9999, 1'b1);
        exp_b = '0;
        total++;
        if (b !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_with_valid got b=%h v=%b exp b=00000000 v=0", b, out_valid);
        end
    endtask

    task automatic test_random();
        logic             r, iv, sv;
        logic [IN_W-1:0]  av;
        logic             exp_v;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            iv = ($urandom_range(0, 3) != 0);
            sv = 1'($urandom);
            av = 16'($urandom);
            step(r, iv, av, sv);
            if (r) begin
                exp_b = '0;
                exp_v = 1'b0;
            end else if (iv) begin
                exp_b = model_ext(av, sv);
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            total++;
            if (b !== exp_b || out_valid !== exp_v) begin
                bad++;
                $display("FAIL random[%0d] rst=%b iv=%b a=%h sext=%b got b=%h v=%b exp b=%h v=%b",
                         i, r, iv, av, sv, b, out_valid, exp_b, exp_v);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        sext     = 1'b0;
        exp_b    = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
